vector_addsub_seq: RTL and testbench

- Time-multiplexed signed vector add/subtract engine for the RLS datapath.
- Processes SIZE elements of WIDTH bits using LANES parallel adders per cycle.
- Adds wrap/saturate modes, a start/ready/done handshake, input capture and an overflow flag.
- Drop-in producer for the vector update stages.

---
 rtl/vector_addsub_seq.sv | 115 +++++++++++
 tb/tb_vector_addsub_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_addsub_seq.sv
// Time-multiplexed signed vector add/subtract engine.
// The engine processes LANES elements per pass over PASSES passes. It supports
// wrap and saturate arithmetic and reports a per-operation overflow flag.
// c is updated only at completion, so callers never see partial results.
module vector_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 16,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [WIDTH*SIZE-1:0] a,
  input  logic [WIDTH*SIZE-1:0] b,
  output logic                  ready,
  output logic                  done,
  output logic [WIDTH*SIZE-1:0] c,
  output logic                  ovf
);

  localparam int PASSES = (SIZE + LANES - 1) / LANES;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int SW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  // Wide enough to hold pass*LANES+LANES-1 without wrapping, so the
  // out-of-range test on the final partial pass is exact.
  localparam int IW     = $clog2(PASSES * LANES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                        state;
  logic [SIZE-1:0][WIDTH-1:0]    a_q, b_q, work;
  logic [1:0]                    mode_q;
  logic [PW-1:0]                 pass;
  logic                          acc;

  logic [LANES-1:0][WIDTH-1:0]   lane_res;
  logic [LANES-1:0]              lane_ovf;
  logic [LANES-1:0]              lane_vld;

  assign ready = (state == S_IDLE);

  for (genvar l = 0; l < LANES; l++) begin : lane_g
    logic [IW-1:0]    idx;
    logic [SW-1:0]    sel;
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH:0]   sum;

    assign idx         = IW'(pass) * IW'(LANES) + IW'(l);
    assign lane_vld[l] = idx < IW'(SIZE);
    // Lanes beyond the vector end read element 0. Their results are
    // discarded, so the value is harmless.
    assign sel         = lane_vld[l] ? SW'(idx) : '0;
    assign opa         = a_q[sel];
    assign opb         = b_q[sel];
    // The sum has one guard bit. It overflows when the top two bits disagree.
    assign sum         = mode_q[0] ? ({opa[WIDTH-1], opa} - {opb[WIDTH-1], opb})
                                   : ({opa[WIDTH-1], opa} + {opb[WIDTH-1], opb});
    assign lane_ovf[l] = sum[WIDTH] ^ sum[WIDTH-1];
    assign lane_res[l] = (lane_ovf[l] && mode_q[1])
                         ? (sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                         : sum[WIDTH-1:0];
  end

  // Control FSM plus capture, working-result and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      work   <= '0;
      pass   <= '0;
      acc    <= 1'b0;
      c      <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
            acc    <= 1'b0;
            pass   <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          // Element e belongs to pass e/LANES on lane e%LANES.
          for (int e = 0; e < SIZE; e++) begin
            if (pass == PW'(e / LANES)) work[e] <= lane_res[e % LANES];
          end
          acc <= acc | (|(lane_ovf & lane_vld));
          if (pass == PW'(PASSES - 1)) begin
            pass  <= '0;
            state <= S_DONE;
          end else begin
            pass <= pass + PW'(1);
          end
        end
        S_DONE: begin
          c     <= work;
          ovf   <= acc;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_addsub_seq.sv
// Self-checking bench for vector_addsub_seq.
// It drives two instances: the default 4-lane build and a 3-lane build.
module tb_vector_addsub_seq;

  localparam int W = 32;
  localparam int N = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0, start3 = 1'b0;
  logic [1:0]       mode = '0, mode3 = '0;
  logic [W*N-1:0]   a = '0, b = '0, a3 = '0, b3 = '0;
  logic             ready, done, ovf, ready3, done3, ovf3;
  logic [W*N-1:0]   c, c3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W*N-1:0] c;
    logic           ovf;
  } exp_t;

  exp_t sb[$];
  exp_t sb3[$];

  vector_addsub_seq #(.WIDTH(W), .SIZE(N), .LANES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .a(a), .b(b),
    .ready(ready), .done(done), .c(c), .ovf(ovf)
  );

  vector_addsub_seq #(.WIDTH(W), .SIZE(N), .LANES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .mode(mode3), .a(a3), .b(b3),
    .ready(ready3), .done(done3), .c(c3), .ovf(ovf3)
  );

  always #5 clk = ~clk;

  // Reference model: 64-bit integer arithmetic with explicit range tests.
  function automatic exp_t model(input logic [1:0] m, input logic [W*N-1:0] av, input logic [W*N-1:0] bv);
    exp_t   e;
    longint x, y, s;
    logic [W-1:0] r;
    logic   o;
    e.c   = '0;
    e.ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      x = longint'($signed(av[W*i +: W]));
      y = longint'($signed(bv[W*i +: W]));
      s = m[0] ? (x - y) : (x + y);
      o = (s > MAXV) || (s < MINV);
      if (o && m[1]) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else           r = s[W-1:0];
      e.c[W*i +: W] = r;
      e.ovf = e.ovf | o;
    end
    return e;
  endfunction

  // Push the expected result, then pulse start for one edge (E0).
  task automatic start_op(input bit sel, input logic [1:0] m, input logic [W*N-1:0] av, input logic [W*N-1:0] bv);
    if (sel) begin
      sb3.push_back(model(m, av, bv));
      mode3 = m; a3 = av; b3 = bv; start3 = 1'b1;
    end else begin
      sb.push_back(model(m, av, bv));
      mode = m; a = av; b = bv; start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; start3 = 1'b0;
  endtask

  // Count edges until done (lat=-1 if the bound expires); note any c change before done.
  task automatic wait_done(input bit sel, output int lat, output bit stable);
    logic [W*N-1:0] c0;
    bit hit;
    c0 = sel ? c3 : c;
    lat = -1; stable = 1'b1; hit = 1'b0;
    for (int k = 1; k <= 40 && !hit; k++) begin
      @(posedge clk); #1;
      if (sel ? done3 : done) begin
        lat = k; hit = 1'b1;
      end else if ((sel ? c3 : c) !== c0) begin
        stable = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (c !== '0) begin errors++; $display("FAIL reset_c: got %h expected 0", c); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL reset_ready3: got %b expected 1", ready3); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_wrap();
    logic [W*N-1:0] av, bv;
    int lat; bit stable; exp_t e;
    for (int i = 0; i < N; i++) begin
      av[W*i +: W] = W'(i);
      bv[W*i +: W] = W'(100 * i);
    end
    start_op(0, 2'b00, av, bv);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL add_ready_busy: got %b expected 0", ready); end
    wait_done(0, lat, stable);
    checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency: got %0d expected 5", lat); end
    checks++; if (!stable) begin errors++; $display("FAIL add_c_early: got changed expected stable"); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL add_ready_idle: got %b expected 1", ready); end
    e = sb.pop_front();
    checks++; if (c !== e.c) begin errors++; $display("FAIL add_c: got %h expected %h", c, e.c); end
    checks++; if (c[W*15 +: W] !== 32'd1515) begin errors++; $display("FAIL add_c15: got %0d expected 1515", c[W*15 +: W]); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf: got %b expected 0", ovf); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_width: got %b expected 0", done); end
  endtask

  task automatic test_sub_capture();
    logic [W*N-1:0] av, bv;
    int lat; bit stable; exp_t e;
    for (int i = 0; i < N; i++) begin
      av[W*i +: W] = 32'd5;
      bv[W*i +: W] = 32'd7;
    end
    start_op(0, 2'b01, av, bv);
    a = '0; b = '0;
    wait_done(0, lat, stable);
    checks++; if (lat !== 5) begin errors++; $display("FAIL sub_latency: got %0d expected 5", lat); end
    e = sb.pop_front();
    checks++; if (c !== e.c) begin errors++; $display("FAIL sub_c: got %h expected %h", c, e.c); end
    checks++; if (c[W*9 +: W] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_c9: got %h expected fffffffe", c[W*9 +: W]); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_overflow();
    logic [W*N-1:0] av, bv;
    logic [1:0]     md [3];
    logic [W-1:0]   a3v [3];
    logic [W-1:0]   want [3];
    int lat; bit stable; exp_t e;
    md[0] = 2'b00; a3v[0] = 32'h7FFF_FFFF; want[0] = 32'h8000_0000;
    md[1] = 2'b10; a3v[1] = 32'h7FFF_FFFF; want[1] = 32'h7FFF_FFFF;
    md[2] = 2'b11; a3v[2] = 32'h8000_0000; want[2] = 32'h8000_0000;
    for (int t = 0; t < 3; t++) begin
      av = '0; bv = '0;
      av[W*3 +: W] = a3v[t];
      bv[W*3 +: W] = 32'd1;
      start_op(0, md[t], av, bv);
      wait_done(0, lat, stable);
      e = sb.pop_front();
      checks++; if (c[W*3 +: W] !== want[t]) begin errors++; $display("FAIL ovf_c3_mode%0d: got %h expected %h", t, c[W*3 +: W], want[t]); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag_mode%0d: got %b expected 1", t, ovf); end
      checks++; if (c !== e.c) begin errors++; $display("FAIL ovf_c_mode%0d: got %h expected %h", t, c, e.c); end
    end
  endtask

  task automatic test_lanes3();
    logic [W*N-1:0] av, bv;
    int lat; bit stable; exp_t e;
    for (int i = 0; i < N; i++) begin
      av[W*i +: W] = W'(i);
      bv[W*i +: W] = 32'd1;
    end
    start_op(1, 2'b00, av, bv);
    wait_done(1, lat, stable);
    checks++; if (lat !== 7) begin errors++; $display("FAIL l3_latency: got %0d expected 7", lat); end
    checks++; if (!stable) begin errors++; $display("FAIL l3_c_early: got changed expected stable"); end
    e = sb3.pop_front();
    checks++; if (c3 !== e.c) begin errors++; $display("FAIL l3_c: got %h expected %h", c3, e.c); end
    checks++; if (c3[W*15 +: W] !== 32'd16) begin errors++; $display("FAIL l3_c15: got %0d expected 16", c3[W*15 +: W]); end
    checks++; if (ovf3 !== 1'b0) begin errors++; $display("FAIL l3_ovf: got %b expected 0", ovf3); end
  endtask

  task automatic test_back_to_back();
    logic [W*N-1:0] av, bv;
    int lat; bit stable; exp_t e;
    for (int i = 0; i < N; i++) begin
      av[W*i +: W] = $urandom;
      bv[W*i +: W] = $urandom;
    end
    start_op(0, 2'b00, av, bv);
    wait_done(0, lat, stable);
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_lat1: got %0d expected 5", lat); end
    // Still inside the done cycle: the second start must be accepted now.
    start_op(0, 2'b01, av, bv);
    e = sb.pop_front();
    checks++; if (c !== e.c || ovf !== e.ovf) begin errors++; $display("FAIL b2b_res1: got %h/%b expected %h/%b", c, ovf, e.c, e.ovf); end
    wait_done(0, lat, stable);
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_gap: got %0d expected 5 (6 cycles between dones)", lat); end
    checks++; if (!stable) begin errors++; $display("FAIL b2b_c_early: got changed expected stable"); end
    e = sb.pop_front();
    checks++; if (c !== e.c || ovf !== e.ovf) begin errors++; $display("FAIL b2b_res2: got %h/%b expected %h/%b", c, ovf, e.c, e.ovf); end
  endtask

  task automatic test_random();
    logic [W*N-1:0] av, bv;
    int lat; bit stable; exp_t e;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        av[W*i +: W] = $urandom;
        bv[W*i +: W] = (t < 4) ? $urandom : $urandom_range(0, 255);
      end
      start_op(0, 2'(t), av, bv);
      wait_done(0, lat, stable);
      e = sb.pop_front();
      checks++; if (c !== e.c || ovf !== e.ovf) begin errors++; $display("FAIL rand%0d: got %h/%b expected %h/%b", t, c, ovf, e.c, e.ovf); end
    end
  endtask

  task automatic test_reset_mid();
    logic [W*N-1:0] av, bv;
    int lat; bit stable; exp_t e;
    for (int i = 0; i < N; i++) begin
      av[W*i +: W] = W'(3 * i + 1);
      bv[W*i +: W] = W'(i);
    end
    mode = 2'b00; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++; if (c !== '0) begin errors++; $display("FAIL rstmid_c: got %h expected 0", c); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done%0d: got %b expected 0", k, done); end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    start_op(0, 2'b01, av, bv);
    wait_done(0, lat, stable);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rstmid_lat: got %0d expected 5", lat); end
    e = sb.pop_front();
    checks++; if (c !== e.c || ovf !== e.ovf) begin errors++; $display("FAIL rstmid_res: got %h/%b expected %h/%b", c, ovf, e.c, e.ovf); end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub_capture();
    test_overflow();
    test_lanes3();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
